mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single MMU memory port between the core load/store path (C)
//   and the DMA/boot-loader engine (D). At most one access is issued per
//   clock. Every read is tagged with its issuer, and the MMU read data is
//   routed back to that issuer RD_LATENCY cycles after the issue.
//
//   Build option MEM_ARB_FIXED_PRIO_EN:
//     undefined : round-robin between C and D (last_gnt register).
//     defined   : C has fixed priority. D gets a forced win once it has
//                 waited STARVE_LIMIT cycles (wait_cnt register).
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata    C request (held stable until c_gnt)
//   c_gnt                        C accepted this cycle (combinational)
//   c_rvalid/c_rdata             C read return (rdata is 0 when not valid)
//   d_*                          same set for port D
//   mem_en/mem_we/mem_addr/
//   mem_wdata                    issue to MMU (all 0 when mem_en=0)
//   mem_rdata                    MMU read data, RD_LATENCY after a read
//   owner                        issuer of current access (0=C, 1=D),
//                                holds the last value while idle
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner
);

    // Elaboration-time range checks on the parameters.
    if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
        $error("mem_port_arbiter: RD_LATENCY must be 1..3");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
        $error("mem_port_arbiter: STARVE_LIMIT must be 1..15");
    end

    logic                  owner_q;
    logic [RD_LATENCY-1:0] tag_v;
    logic [RD_LATENCY-1:0] tag_o;
    logic                  rd_issue;

    // ------------------------------------------------------------------
    // Grant logic. Grants depend only on req inputs and registered state,
    // and are forced low while reset is asserted.
    // ------------------------------------------------------------------
`ifdef MEM_ARB_FIXED_PRIO_EN
    logic [3:0] wait_cnt;
    logic       d_win;

    // D wins when alone, or when it has starved long enough.
    assign d_win = d_req && (!c_req || (wait_cnt >= 4'(STARVE_LIMIT)));

    always_comb begin
        c_gnt = reset_n && c_req && !d_win;
        d_gnt = reset_n && d_win;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 4'd0;
        end else if (!d_req || d_gnt) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != 4'd15) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end
`else
    logic last_gnt;   // 0 = C granted last, 1 = D granted last

    always_comb begin
        c_gnt = reset_n && c_req && (!d_req ||  last_gnt);
        d_gnt = reset_n && d_req && (!c_req || !last_gnt);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt <= 1'b1;
        end else if (c_gnt) begin
            last_gnt <= 1'b0;
        end else if (d_gnt) begin
            last_gnt <= 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Issue mux towards the MMU.
    // ------------------------------------------------------------------
    always_comb begin
        mem_en    = c_gnt | d_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        owner     = owner_q;
        if (c_gnt) begin
            mem_we    = c_we;
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
            owner     = 1'b0;
        end else if (d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            owner     = 1'b1;
        end
    end

    assign rd_issue = mem_en && !mem_we;

    // ------------------------------------------------------------------
    // Owner hold register and read tag pipeline. Reset clears every
    // in-flight tag, so late MMU data after a reset is never routed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q <= 1'b0;
            tag_v   <= '0;
            tag_o   <= '0;
        end else begin
            owner_q  <= owner;
            tag_v[0] <= rd_issue;
            tag_o[0] <= owner;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_o[i] <= tag_o[i-1];
            end
        end
    end

    always_comb begin
        c_rvalid = tag_v[RD_LATENCY-1] && !tag_o[RD_LATENCY-1];
        d_rvalid = tag_v[RD_LATENCY-1] &&  tag_o[RD_LATENCY-1];
        c_rdata  = c_rvalid ? mem_rdata : '0;
        d_rdata  = d_rvalid ? mem_rdata : '0;
    end

endmodule
